// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I OP/OP-IMM words, reads the register file with
// writeback bypass, and holds one operand bundle for the ALU.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_inst_valid/o_inst_ready      instruction handshake, i_inst word
//   i_wb_en/i_wb_rd/i_wb_data      register file write port
//   o_ex_valid/i_ex_ready          operand bundle handshake
//   o_ex_a/o_ex_b                  operands (rs1, rs2 or sign-extended imm)
//   o_ex_func3/o_ex_func7/o_ex_rd  ALU op fields and destination
//   o_illegal                      pulse after an illegal word is consumed
module alu_issue #(
    parameter bit CLEAR_REGS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inst_valid,
    output logic        o_inst_ready,
    input  logic [31:0] i_inst,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_ex_valid,
    input  logic        i_ex_ready,
    output logic [31:0] o_ex_a,
    output logic [31:0] o_ex_b,
    output logic [2:0]  o_ex_func3,
    output logic [6:0]  o_ex_func7,
    output logic [4:0]  o_ex_rd,
    output logic        o_illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [31:0] r_regs [0:31];

    logic        r_valid;
    logic        r_illegal;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [4:0]  r_rd;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7_in;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_wr;
    logic        w_accept;
    logic        w_legal;
    logic        w_use_imm;
    logic [6:0]  w_f7_out;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_b;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7_in = i_inst[31:25];
    assign w_rs1   = i_inst[19:15];
    assign w_rs2   = i_inst[24:20];

    assign w_wr = i_wb_en && (i_wb_rd != 5'd0);

    // Single output register: a new word may enter when the slot
    // is empty or is being drained this same edge.
    assign o_inst_ready = !r_valid || i_ex_ready;
    assign w_accept     = i_inst_valid && o_inst_ready;

    // Same-cycle writeback wins over the stale array entry.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                       (w_wr && i_wb_rd == w_rs1) ? i_wb_data :
                       r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                       (w_wr && i_wb_rd == w_rs2) ? i_wb_data :
                       r_regs[w_rs2];

    always_comb begin
        w_legal   = 1'b0;
        w_use_imm = 1'b0;
        w_f7_out  = 7'd0;
        if (w_opc == OPC_OP) begin
            w_f7_out = w_f7_in;
            w_legal  = (w_f7_in == 7'd0) ||
                       (w_f7_in == F7_ALT &&
                        (w_f3 == 3'b000 || w_f3 == 3'b101));
        end else if (w_opc == OPC_IMM) begin
            w_use_imm = 1'b1;
            case (w_f3)
                3'b001:  w_legal = (w_f7_in == 7'd0);
                3'b101: begin
                    w_legal  = (w_f7_in == 7'd0) || (w_f7_in == F7_ALT);
                    w_f7_out = w_f7_in;
                end
                // Plain immediates: func7 forced to 0 so ADDI never subtracts.
                default: w_legal = 1'b1;
            endcase
        end
    end

    assign w_b = w_use_imm ? {{20{i_inst[31]}}, i_inst[31:20]} : w_rs2_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_f3      <= '0;
            r_f7      <= '0;
            r_rd      <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_valid <= 1'b1;
                r_a     <= w_rs1_val;
                r_b     <= w_b;
                r_f3    <= w_f3;
                r_f7    <= w_f7_out;
                r_rd    <= i_inst[11:7];
            end else if (i_ex_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    generate
        if (CLEAR_REGS) begin : g_rf_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) r_regs[i] <= '0;
                end else if (w_wr) begin
                    r_regs[i_wb_rd] <= i_wb_data;
                end
            end
        end else begin : g_rf_nrst
            always_ff @(posedge clk) begin
                if (w_wr) r_regs[i_wb_rd] <= i_wb_data;
            end
        end
    endgenerate

    assign o_ex_valid = r_valid;
    assign o_illegal  = r_illegal;
    assign o_ex_a     = r_a;
    assign o_ex_b     = r_b;
    assign o_ex_func3 = r_f3;
    assign o_ex_func7 = r_f7;
    assign o_ex_rd    = r_rd;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a
// transaction-level reference model of the issue slot and register file.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_inst_valid = 1'b0;
    logic        o_inst_ready;
    logic [31:0] i_inst = '0;
    logic        i_wb_en = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_ex_valid;
    logic        i_ex_ready = 1'b0;
    logic [31:0] o_ex_a;
    logic [31:0] o_ex_b;
    logic [2:0]  o_ex_func3;
    logic [6:0]  o_ex_func7;
    logic [4:0]  o_ex_rd;
    logic        o_illegal;

    alu_issue #(.CLEAR_REGS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
        .i_inst(i_inst),
        .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_a(o_ex_a), .o_ex_b(o_ex_b),
        .o_ex_func3(o_ex_func3), .o_ex_func7(o_ex_func7),
        .o_ex_rd(o_ex_rd), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_valid;
    bit          m_illegal;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_illegal = 0;
        m_a = '0; m_b = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
    endtask

    // RV32I OP / OP-IMM legality and ALU modifier rules
    function automatic void ref_decode(input logic [31:0] w, output bit ok,
                                       output logic [6:0] f7,
                                       output bit use_imm);
        logic [2:0] f3;
        logic [6:0] hi;
        f3 = w[14:12];
        hi = w[31:25];
        ok = 0; f7 = '0; use_imm = 0;
        if (w[6:0] == 7'h33) begin
            f7 = hi;
            ok = (hi == 7'h00) || (hi == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (w[6:0] == 7'h13) begin
            use_imm = 1;
            if (f3 == 3'd1) ok = (hi == 7'h00);
            else if (f3 == 3'd5) begin
                ok = (hi == 7'h00) || (hi == 7'h20);
                f7 = hi;
            end else ok = 1;
        end
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input bit we,
                                             input logic [4:0] wrd,
                                             input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && wrd == r) return wd;
        return m_regs[r];
    endfunction

    task automatic check_outputs(input string pfx);
        chk({pfx, ".ex_valid"}, 32'(o_ex_valid), 32'(m_valid));
        chk({pfx, ".illegal"}, 32'(o_illegal), 32'(m_illegal));
        chk({pfx, ".ex_a"}, o_ex_a, m_a);
        chk({pfx, ".ex_b"}, o_ex_b, m_b);
        chk({pfx, ".func3"}, 32'(o_ex_func3), 32'(m_f3));
        chk({pfx, ".func7"}, 32'(o_ex_func7), 32'(m_f7));
        chk({pfx, ".ex_rd"}, 32'(o_ex_rd), 32'(m_rd));
    endtask

    // One clock: drive, check inst_ready, advance model, check outputs.
    task automatic step(input bit v, input logic [31:0] ins, input bit rdy,
                        input bit we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        bit acc, ok, use_imm, exp_rdy;
        logic [6:0] f7;
        i_inst_valid = v; i_inst = ins; i_ex_ready = rdy;
        i_wb_en = we; i_wb_rd = wrd; i_wb_data = wd;
        #1;
        exp_rdy = !m_valid || rdy;
        chk("inst_ready", 32'(o_inst_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        ref_decode(ins, ok, f7, use_imm);
        m_illegal = acc && !ok;
        if (acc && ok) begin
            m_valid = 1;
            m_a  = ref_read(ins[19:15], we, wrd, wd);
            m_b  = use_imm ? {{20{ins[31]}}, ins[31:20]}
                           : ref_read(ins[24:20], we, wrd, wd);
            m_f3 = ins[14:12];
            m_f7 = f7;
            m_rd = ins[11:7];
        end else if (rdy) begin
            m_valid = 0;
        end
        if (we && wrd != 0) m_regs[wrd] = wd;
        @(posedge clk);
        #1;
        check_outputs("out");
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int sel;
        sel = $urandom_range(0, 9);
        w = $urandom();
        if (sel < 8) begin
            w[6:0]   = (sel < 4) ? 7'h33 : 7'h13;
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: w[31:25] = 7'($urandom());
            endcase
        end
        return w;
    endfunction

    initial begin
        model_reset();
        #12;
        chk("rst.ex_valid", 32'(o_ex_valid), 32'd0);
        chk("rst.illegal", 32'(o_illegal), 32'd0);
        chk("rst.ex_a", o_ex_a, 32'd0);
        chk("rst.ex_rd", 32'(o_ex_rd), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        step(0, 0, 1, 1, 5'd1, 32'd5);
        step(0, 0, 1, 1, 5'd2, 32'd3);
        step(1, 32'h002081B3, 1, 0, 0, 0);
        chk("add.valid", 32'(o_ex_valid), 32'd1);
        chk("add.a", o_ex_a, 32'd5);
        chk("add.b", o_ex_b, 32'd3);
        chk("add.f3", 32'(o_ex_func3), 32'd0);
        chk("add.f7", 32'(o_ex_func7), 32'd0);
        chk("add.rd", 32'(o_ex_rd), 32'd3);

        step(1, 32'h402081B3, 1, 0, 0, 0);
        chk("sub.f7", 32'(o_ex_func7), 32'h20);

        step(1, 32'hFFF08213, 1, 0, 0, 0);
        chk("addi.b", o_ex_b, 32'hFFFFFFFF);
        chk("addi.f7", 32'(o_ex_func7), 32'd0);

        step(1, 32'h4040D293, 1, 0, 0, 0);
        chk("srai.b", o_ex_b, 32'h404);
        chk("srai.f7", 32'(o_ex_func7), 32'h20);

        for (int i = 0; i < 3; i++) begin
            step(1, 32'h002081B3, 0, 0, 0, 0);
            chk("stall.rd", 32'(o_ex_rd), 32'd5);
            chk("stall.b", o_ex_b, 32'h404);
        end
        step(1, 32'h002081B3, 1, 0, 0, 0);
        chk("release.rd", 32'(o_ex_rd), 32'd3);
        chk("release.valid", 32'(o_ex_valid), 32'd1);

        step(1, 32'h00008313, 1, 1, 5'd1, 32'h77);
        chk("bypass.a", o_ex_a, 32'h77);

        step(0, 0, 1, 1, 5'd0, 32'hDEAD);
        step(1, 32'h00000313, 1, 0, 0, 0);
        chk("x0.a", o_ex_a, 32'd0);

        step(1, 32'h00000073, 1, 0, 0, 0);
        chk("ecall.illegal", 32'(o_illegal), 32'd1);
        chk("ecall.valid", 32'(o_ex_valid), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        chk("ecall.pulse", 32'(o_illegal), 32'd0);

        step(1, 32'h40009293, 1, 0, 0, 0);
        chk("slli.illegal", 32'(o_illegal), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8, rand_inst(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom());
        end

        // Reset in the middle of a stall
        step(0, 0, 1, 1, 5'd1, 32'h1234);
        step(1, 32'h002081B3, 1, 0, 0, 0);
        step(1, 32'h002081B3, 0, 0, 0, 0);
        chk("prerst.valid", 32'(o_ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(o_ex_valid), 32'd0);
        chk("midrst.a", o_ex_a, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 32'h00008313, 1, 0, 0, 0);
        chk("postrst.x1", o_ex_a, 32'd0);
        chk("postrst.valid", 32'(o_ex_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer end of the ALU operand interface.
- Accepts 32-bit RV32I instruction words from fetch and decodes OP (0110011) and OP-IMM (0010011).
- Reads an internal 32x32 register file with writeback bypass.
- Presents registered operands a/b, func3/func7 and destination to the ALU and execute stage over a valid/ready handshake.
- Owns the register file; the writeback port from the result path writes into it.

Parameters:
- CLEAR_REGS, 1, when 1 reset clears x1..x31 to 0; when 0 the register array has no reset (outputs still reset).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction word valid
- inst_ready  out  1  block can accept instruction this cycle
- inst  in  32  instruction word
- wb_en  in  1  register write enable
- wb_rd  in  5  register write index
- wb_data  in  32  register write data
- ex_valid  out  1  operand bundle valid
- ex_ready  in  1  execute stage accepts bundle
- ex_a  out  32  operand a = rs1 value
- ex_b  out  32  operand b = rs2 value or sign-extended immediate
- ex_func3  out  3  inst[14:12]
- ex_func7  out  7  ALU modifier (see Behaviour)
- ex_rd  out  5  destination register
- illegal  out  1  one-cycle pulse: accepted word was not a legal OP/OP-IMM

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid=0, illegal=0.
  - ex_a, ex_b, ex_func3, ex_func7, ex_rd = 0.
  - x1..x31 = 0 if CLEAR_REGS.
  - Takes effect immediately mid-operation; any held bundle is discarded.
- Handshake:
  - inst_ready = !ex_valid || ex_ready (combinational; single output register stage).
  - Accept when inst_valid && inst_ready.
  - Latency is 1 cycle: accepted at edge N gives ex_valid=1 after edge N if legal.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
  - ex_valid clears on ex_ready unless a new legal word is accepted the same edge. Back-to-back throughput is 1/cycle.
- Decode:
  - rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], func3=inst[14:12].
- OP:
  - ex_b=R[rs2], ex_func7=inst[31:25].
  - Legal iff func7==0000000, or func7==0100000 with func3 in {000,101}.
- OP-IMM:
  - ex_b = sign-extend inst[31:20].
  - func3 in {000,010,011,100,110,111}: ex_func7=0000000, so ADDI never subtracts.
  - func3==001: legal iff inst[31:25]==0000000; ex_func7=0000000.
  - func3==101: legal iff inst[31:25] in {0000000,0100000}; ex_func7=inst[31:25].
- Any other opcode or illegal encoding:
  - The word is still consumed (inst_ready handshake completes).
  - No bundle is produced; ex_valid is unaffected by that word.
  - illegal=1 for exactly the cycle after acceptance.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes occur on any edge with wb_en, independent of stall state.
- Bypass:
  - On acceptance, if wb_en && wb_rd!=0 && wb_rd==rs, the operand takes wb_data, not the stale array value.
  - A bundle already held in ex_* is NOT updated by later writebacks. RAW hazards against in-flight instructions are the upstream controller's responsibility.
- Simultaneous events:
  - ex_ready drop and new inst_valid in the same cycle: inst_ready=0, the word is not taken.
  - Illegal accepted while an old bundle drains (ex_ready=1): ex_valid goes 0 and illegal goes 1 at the same edge.

Test Plan:
- Reset then wb x1=5, x2=3; issue ADD x3,x1,x2 (0x002081B3) with ex_ready=1 -> next cycle ex_valid=1, ex_a=5, ex_b=3, ex_func3=0, ex_func7=0, ex_rd=3.
- SUB x3,x1,x2 (0x402081B3) -> ex_func7=0x20.
- ADDI x4,x1,-1 (0xFFF08213) -> ex_b=0xFFFFFFFF, ex_func7=0.
- SRAI x5,x1,4 (0x4040D293) -> ex_b=0x404, ex_func7=0x20.
- ex_ready=0 with bundle held for 3 cycles while inst_valid=1 -> inst_ready=0; ex_* unchanged.
- Release ex_ready -> next word is taken that same edge; no bubble.
- Same-cycle wb_en (x1=0x77) and issue of ADDI x6,x1,0 -> ex_a=0x77.
- wb to x0 with 0xDEAD, then read x0 -> ex_a=0.
- Issue opcode 0x00000073 -> word consumed, illegal=1 for one cycle, ex_valid=0.
- SLLI with inst[31:25]=0x20 -> illegal=1.
- Assert rst_n=0 mid-stall -> ex_valid=0 immediately; on release a held x1 reads 0 (CLEAR_REGS=1).
